multiword_add_sequencer: RTL and testbench

//  Multi-cycle wide adder/subtractor that time-shares one CHUNK-bit ripple

---
 rtl/multiword_add_sequencer.sv | 114 +++++++++++
 tb/tb_multiword_add_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer.sv
// Wide adder/subtractor that reuses one CHUNK-bit ripple slice over WIDTH-bit
// operands, one chunk per clock with the LSB chunk first, behind valid/ready handshakes.
module multiword_add_sequencer #(
    parameter int WIDTH = 16,  // must be a positive multiple of CHUNK
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CHUNK:0]     slice;

    // NOTE: every register, including the operand and result stores, is cleared
    // by the asynchronous reset, so an aborted op never leaks a partial result.
    // NOTE: state registers use non-blocking assignments only. This avoids
    // ordering races between clocked processes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: every next-state value defaults to its current value first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        slice   = {1'b0, a_q[idx_q*CHUNK +: CHUNK]}
                + {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, carry_q};

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Subtraction runs as a + ~b + 1, so the slice only ever adds.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub | cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[idx_q*CHUNK +: CHUNK] = slice[CHUNK-1:0];
                carry_d = slice[CHUNK];
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice[CHUNK];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) && rst_n;
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        sum       = sum_q;
        cout      = cout_q;
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer. It runs a 4-chunk and a
// 1-chunk instance on shared stimulus and checks them against an arithmetic model.
module tb_multiword_add_sequencer;

    localparam int W = 16;
    localparam int NC[2] = '{4, 1};

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic [1:0]   out_ready = 2'b00;
    logic [1:0]   in_ready, out_valid, cout, busy;
    logic [W-1:0] sum [2];

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    multiword_add_sequencer #(.WIDTH(W), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .sum(sum[0]), .cout(cout[0]), .busy(busy[0])
    );

    multiword_add_sequencer #(.WIDTH(W), .CHUNK(16)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .sum(sum[1]), .cout(cout[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: plain unsigned arithmetic; for subtraction cout means "no borrow".
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        res_t        r;
        logic [31:0] t;
        if (s) begin
            r.s  = x - y;
            r.co = (x >= y);
        end else begin
            t    = 32'(x) + 32'(y) + 32'(c);
            r.s  = t[W-1:0];
            r.co = t[W];
        end
        return r;
    endfunction

    // Scoreboard and latency monitor, sampled on the falling edge.
    res_t       sb [2][$];
    int         acc_cyc [2][$];
    int         acc_t [2][$];
    logic [1:0] ov_prev = 2'b00;
    res_t       e_mon;
    int         t_mon;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                sb[d].delete();
                acc_cyc[d].delete();
            end else begin
                if (out_valid[d] && !ov_prev[d]) begin
                    if (acc_cyc[d].size() == 0) begin
                        check($sformatf("dut%0d result without accept", d), 1, 0);
                    end else begin
                        t_mon = acc_cyc[d].pop_front();
                        check($sformatf("dut%0d latency", d), cyc - t_mon, NC[d]);
                    end
                    check($sformatf("dut%0d in_ready while out_valid", d), in_ready[d], 0);
                end
                if (out_valid[d] && out_ready[d]) begin
                    if (sb[d].size() == 0) begin
                        check($sformatf("dut%0d unexpected result", d), 1, 0);
                    end else begin
                        e_mon = sb[d].pop_front();
                        check($sformatf("dut%0d scoreboard", d), {cout[d], sum[d]}, {e_mon.co, e_mon.s});
                    end
                end
                if (in_valid && in_ready[d]) begin
                    sb[d].push_back(model(a, b, cin, sub));
                    acc_cyc[d].push_back(cyc + 1);
                    acc_t[d].push_back(cyc + 1);
                end
            end
            ov_prev[d] = out_valid[d];
        end
    end

    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tcin, input logic tsub, input logic [W-1:0] es, input logic eco);
        @(posedge clk); #1;
        a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 2'b00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        for (int k = 0; k < 20; k++) begin
            if (out_valid == 2'b11) break;
            @(posedge clk); #1;
        end
        check({name, " valid"}, out_valid, 2'b11);
        check({name, " dut0"}, {cout[0], sum[0]}, {eco, es});
        check({name, " dut1"}, {cout[1], sum[1]}, {eco, es});
        out_ready = 2'b11;
        @(posedge clk); #1;
        out_ready = 2'b00;
        check({name, " idle after"}, {out_valid, in_ready}, {2'b00, 2'b11});
    endtask

    vec_t         vecs [8];
    res_t         r;
    logic [W-1:0] held_sum;
    logic         held_cout;
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    int           bad;

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0};
        vecs[6] = '{16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1};
        vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0};

        // Reset state.
        #12;
        check("reset outputs dut0", {out_valid[0], busy[0], cout[0], sum[0]}, '0);
        check("reset outputs dut1", {out_valid[1], busy[1], cout[1], sum[1]}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("in_ready after reset", in_ready, 2'b11);

        // Directed vectors.
        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   vecs[i].s, vecs[i].co);

        // Backpressure: result held while the consumer stalls and inputs wiggle.
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 20; k++) begin
            if (out_valid[0]) break;
            @(posedge clk); #1;
        end
        held_sum = sum[0];
        held_cout = cout[0];
        check("bp result", {held_cout, held_sum}, {1'b0, 16'h5555});
        for (int k = 0; k < 6; k++) begin
            a = ~a; b = b + 16'h1111; sub = ~sub;
            @(posedge clk); #1;
            check("bp hold", {out_valid, in_ready, cout[0], sum[0]}, {2'b11, 2'b00, held_cout, held_sum});
        end
        // in_valid is still high at the result handshake and must not be taken.
        out_ready = 2'b11;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 2'b00;
        check("bp release", {out_valid, busy, in_ready}, {2'b00, 2'b00, 2'b11});

        // Reset during the second RUN cycle (the wide instance is already in DONE).
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid-run reset dut0", {out_valid[0], busy[0], cout[0], sum[0]}, '0);
        check("mid-done reset dut1", {out_valid[1], busy[1], cout[1], sum[1]}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op("after reset", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0);

        // Random ops against the model.
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            if (i % 5 == 0) rb = ra;
            r = model(ra, rb, rc, rs);
            run_op($sformatf("rand%0d", i), ra, rb, rc, rs, r.s, r.co);
        end

        // Back-to-back throughput with in_valid held high and no backpressure.
        @(posedge clk); #1;
        acc_t[0].delete();
        acc_t[1].delete();
        out_ready = 2'b11; in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (busy == 2'b00) break;
            @(posedge clk); #1;
        end
        check("b2b drained", busy, 2'b00);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("b2b accept count dut%0d", d), 32'(acc_t[d].size() >= 40 / (NC[d] + 2)), 1);
            bad = 0;
            for (int i = 1; i < acc_t[d].size(); i++)
                if (acc_t[d][i] - acc_t[d][i-1] != NC[d] + 2) bad++;
            check($sformatf("b2b spacing dut%0d", d), bad, 0);
        end

        @(posedge clk); #1;
        check("scoreboard empty", sb[0].size() + sb[1].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
